// File: rtl/cache_request_dispatcher_pkg.sv
// Shared cache types: decoded address, trace opcodes, queued request and dispatcher state.
// Address split is tag[31:20] / set[19:6] / offset[5:0].
package cache_request_dispatcher_pkg;

  localparam int TAG_W = 12;
  localparam int SET_W = 14;
  localparam int OFF_W = 6;
  localparam int PID_W = 3;
  localparam int OP_W  = 4;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [SET_W-1:0] set_index;
    logic [OFF_W-1:0] byte_offset;
  } address_t;

  typedef enum logic [OP_W-1:0] {
    OP_CACHE0 = 4'd0,
    OP_CACHE1 = 4'd1,
    OP_CACHE2 = 4'd2,
    OP_CACHE3 = 4'd3,
    OP_CACHE4 = 4'd4,
    OP_CLEAR  = 4'd8,
    OP_PRINT  = 4'd9
  } opcode_t;

  typedef struct packed {
    opcode_t          n;
    address_t         address;
    logic [PID_W-1:0] pid;
  } request_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    PRINT = 2'd2
  } state_t;

  function automatic logic is_cache_op(input logic [OP_W-1:0] n);
    return n <= 4'd4;
  endfunction

  function automatic logic is_legal(input logic [OP_W-1:0] n);
    return is_cache_op(n) || (n == OP_CLEAR) || (n == OP_PRINT);
  endfunction

endpackage

// File: rtl/cache_request_dispatcher_req_fifo.sv
// Request FIFO: DEPTH entries, write-to-head latency 1 cycle, no bypass.
// Backpressure via full; the extra pointer bit separates full from empty.
module req_fifo
  import cache_request_dispatcher_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = request_t
) (
  input  logic clk,
  input  logic rst_n,
  input  logic push,
  input  T     push_data,
  input  logic pop,
  output T     head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  T            mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage is left unreset; the consumer masks the head while empty.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/cache_request_dispatcher.sv
// Trace-to-cache dispatcher: filters illegal opcodes, queues requests, issues cache ops and clear/print commands.
// Head reaches req_valid 1 cycle after write; in_ready is plain FIFO-not-full, req stalls hold the head.
module cache_request_dispatcher
  import cache_request_dispatcher_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_n,
  input  logic [31:0]      in_addr,
  input  logic [2:0]       in_pid,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [3:0]       req_n,
  output logic [11:0]      req_tag,
  output logic [13:0]      req_set,
  output logic [5:0]       req_offset,
  output logic [2:0]       req_pid,
  output logic             flush_req,
  input  logic             flush_ack,
  output logic             print_pulse,
  output logic [CNT_W-1:0] issued_cnt,
  output logic [7:0]       dropped_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t   state;
  state_t   state_next;
  request_t in_req;
  request_t head;
  request_t shown;
  logic     fifo_full;
  logic     fifo_empty;
  logic     accept;
  logic     push;
  logic     drop;
  logic     pop;

  assign in_ready = rst_n && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && is_legal(in_n);
  assign drop     = accept && !is_legal(in_n);
  assign in_req   = {in_n, in_addr, in_pid};

  req_fifo #(
    .DEPTH (DEPTH),
    .T     (request_t)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (in_req),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= RUN;
    else        state <= state_next;
  end

  // Clear and print commands are consumed from the head without a cache handshake.
  always_comb begin
    state_next  = state;
    pop         = 1'b0;
    req_valid   = 1'b0;
    flush_req   = 1'b0;
    print_pulse = 1'b0;
    case (state)
      RUN: begin
        if (!fifo_empty) begin
          if (is_cache_op(head.n)) begin
            req_valid = 1'b1;
            pop       = req_ready;
          end else begin
            pop        = 1'b1;
            state_next = (head.n == OP_CLEAR) ? FLUSH : PRINT;
          end
        end
      end
      FLUSH: begin
        flush_req = 1'b1;
        if (flush_ack) state_next = RUN;
      end
      PRINT: begin
        print_pulse = 1'b1;
        state_next  = RUN;
      end
      default: state_next = RUN;
    endcase
  end

  assign shown      = req_valid ? head : '0;
  assign req_n      = shown.n;
  assign req_tag    = shown.address.tag;
  assign req_set    = shown.address.set_index;
  assign req_offset = shown.address.byte_offset;
  assign req_pid    = shown.pid;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      issued_cnt  <= '0;
      dropped_cnt <= '0;
    end else begin
      if (req_valid && req_ready) issued_cnt <= issued_cnt + CNT_ONE;
      if (drop && (dropped_cnt != 8'hFF)) dropped_cnt <= dropped_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_cache_request_dispatcher.sv
// Bench for cache_request_dispatcher: decode vector table, directed corner sequences, random traffic vs event-order model.
module tb_cache_request_dispatcher;

  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [3:0]       in_n = '0;
  logic [31:0]      in_addr = '0;
  logic [2:0]       in_pid = '0;
  logic             req_valid;
  logic             req_ready = 1'b0;
  logic [3:0]       req_n;
  logic [11:0]      req_tag;
  logic [13:0]      req_set;
  logic [5:0]       req_offset;
  logic [2:0]       req_pid;
  logic             flush_req;
  logic             flush_ack = 1'b0;
  logic             print_pulse;
  logic [CNT_W-1:0] issued_cnt;
  logic [7:0]       dropped_cnt;

  cache_request_dispatcher #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_n(in_n), .in_addr(in_addr), .in_pid(in_pid),
    .req_valid(req_valid), .req_ready(req_ready), .req_n(req_n),
    .req_tag(req_tag), .req_set(req_set), .req_offset(req_offset), .req_pid(req_pid),
    .flush_req(flush_req), .flush_ack(flush_ack), .print_pulse(print_pulse),
    .issued_cnt(issued_cnt), .dropped_cnt(dropped_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Events in the order the cache side should see them: 0 issue, 1 clear, 2 print.
  typedef struct packed {
    logic [1:0]  kind;
    logic [3:0]  n;
    logic [31:0] addr;
    logic [2:0]  pid;
  } ev_t;

  function automatic ev_t mk(input logic [1:0] k, input logic [3:0] n, input logic [31:0] a, input logic [2:0] p);
    ev_t e;
    e.kind = k; e.n = n; e.addr = a; e.pid = p;
    return e;
  endfunction

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  pushed = 0, popped = 0, illegal = 0;
  int  ack_delay = 3, flush_len = 0, last_flush_len = 0;
  bit  prev_stall = 0, prev_print = 0;
  ev_t prev_ev;

  // Reference model and protocol monitor, sampled on the falling edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete(); obs_q.delete();
        pushed = 0; popped = 0; illegal = 0;
        flush_len = 0; last_flush_len = 0; flush_ack = 1'b0;
        prev_stall = 0; prev_print = 0;
      end else begin
        if (flush_req && flush_len == 0) begin obs_q.push_back(mk(2'd1, 4'd0, 32'd0, 3'd0)); popped++; end
        if (print_pulse) begin obs_q.push_back(mk(2'd2, 4'd0, 32'd0, 3'd0)); popped++; end
        chk("in_ready_vs_occupancy", in_ready, (pushed - popped) < DEPTH);
        chk("valid_while_empty", req_valid && (pushed == popped), 0);
        chk("strobe_with_valid", req_valid && (flush_req || print_pulse), 0);
        chk("print_two_cycles", print_pulse && prev_print, 0);
        if (prev_stall)
          chk("stall_hold", {req_valid, mk(2'd0, req_n, {req_tag, req_set, req_offset}, req_pid)}, {1'b1, prev_ev});
        prev_ev    = mk(2'd0, req_n, {req_tag, req_set, req_offset}, req_pid);
        prev_stall = req_valid && !req_ready;
        prev_print = print_pulse;
        if (req_valid && req_ready) begin obs_q.push_back(prev_ev); popped++; end
        if (in_valid && in_ready) begin
          if (in_n inside {[4'd0:4'd4]}) begin exp_q.push_back(mk(2'd0, in_n, in_addr, in_pid)); pushed++; end
          else if (in_n == 4'd8) begin exp_q.push_back(mk(2'd1, 4'd0, 32'd0, 3'd0)); pushed++; end
          else if (in_n == 4'd9) begin exp_q.push_back(mk(2'd2, 4'd0, 32'd0, 3'd0)); pushed++; end
          else illegal++;
        end
        if (flush_req) begin
          flush_len++;
          flush_ack = (flush_len >= ack_delay);
        end else begin
          if (flush_len != 0) last_flush_len = flush_len;
          flush_len = 0;
          flush_ack = 1'b0;
        end
      end
    end
  end

  // Callers sit just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [31:0] addr, input logic [2:0] pid);
    int t = 0;
    in_valid = 1'b1; in_n = op; in_addr = addr; in_pid = pid;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      t++;
      if (t > 200) begin chk("send_timeout", 0, 1); break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input bit check);
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b0; req_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    if (check) chk("during_reset_outs", {in_ready, req_valid, flush_req, print_pulse}, 4'b0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    if (check) begin
      chk("after_reset_ready", in_ready, 1);
      chk("after_reset_strobes", {req_valid, flush_req, print_pulse}, 3'b000);
      chk("after_reset_fields", {req_n, req_tag, req_set, req_offset, req_pid}, 0);
      chk("after_reset_counts", {issued_cnt, dropped_cnt}, 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic compare_queues(input string tag);
    int n;
    chk({tag, "_event_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_event%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  typedef struct {
    logic [3:0]  n;
    logic [31:0] addr;
    logic [2:0]  pid;
    logic [11:0] tag;
    logic [13:0] set;
    logic [5:0]  off;
  } vec_t;

  vec_t vecs[5];

  initial begin : main
    int cnt;
    bit acc;
    int r;
    vecs[0] = '{4'd0, 32'h984DE132, 3'd1, 12'h984, 14'h3784, 6'h32};
    vecs[1] = '{4'd1, 32'hFFFFFFFF, 3'd7, 12'hFFF, 14'h3FFF, 6'h3F};
    vecs[2] = '{4'd4, 32'h00000000, 3'd0, 12'h000, 14'h0000, 6'h00};
    vecs[3] = '{4'd2, 32'h12345678, 3'd5, 12'h123, 14'h1159, 6'h38};
    vecs[4] = '{4'd3, 32'h000FFFC0, 3'd2, 12'h000, 14'h3FFF, 6'h00};

    do_reset(1);

    // Single requests into an empty FIFO: visible one cycle after the write.
    req_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].n, vecs[i].addr, vecs[i].pid);
      @(negedge clk);
      chk($sformatf("vec%0d_valid", i), req_valid, 1);
      chk($sformatf("vec%0d_n", i), req_n, vecs[i].n);
      chk($sformatf("vec%0d_tag", i), req_tag, vecs[i].tag);
      chk($sformatf("vec%0d_set", i), req_set, vecs[i].set);
      chk($sformatf("vec%0d_off", i), req_offset, vecs[i].off);
      chk($sformatf("vec%0d_pid", i), req_pid, vecs[i].pid);
      @(posedge clk); #1;
      @(negedge clk);
      chk($sformatf("vec%0d_issued", i), issued_cnt, i + 1);
      chk($sformatf("vec%0d_drained", i), req_valid, 0);
      @(posedge clk); #1;
    end

    // Fill to DEPTH under stall, hold a fifth, then release.
    do_reset(0);
    for (int k = 0; k < 4; k++) begin
      send(k[3:0] % 4'd5, 32'h1000 * k + 32'h40, k[2:0]);
      @(negedge clk);
      chk($sformatf("fill%0d_in_ready", k), in_ready, k < 3);
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_n = 4'd1; in_addr = 32'hCAFE_F00D; in_pid = 3'd6;
    repeat (3) begin
      @(negedge clk);
      chk("fifth_held", in_ready, 0);
    end
    @(posedge clk); #1;
    req_ready = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    req_ready = 1'b0;
    @(negedge clk);
    chk("after_four_issued", issued_cnt, 4);
    chk("fifth_at_head", {req_valid, req_tag, req_set, req_offset}, {1'b1, 32'hCAFE_F00D});
    @(posedge clk); #1;
    req_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("after_five_issued", issued_cnt, 5);
    compare_queues("fill");

    // Clear queued behind two reads, ack after the third flush_req cycle.
    do_reset(0);
    ack_delay = 3;
    send(4'd0, 32'hAAAA_0001, 3'd1);
    send(4'd0, 32'hBBBB_0002, 3'd2);
    send(4'd8, 32'h0, 3'd0);
    req_ready = 1'b1;
    cnt = 0;
    while (!(obs_q.size() >= 3 && flush_len == 0 && last_flush_len != 0) && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("flush_wait_timeout", cnt < 100, 1);
    chk("flush_high_cycles", last_flush_len, 3);
    chk("flush_dropped", flush_req, 0);
    compare_queues("flush");

    // Illegal opcodes are counted and never reach the cache side.
    do_reset(0);
    send(4'd5, 32'h1, 3'd0);
    send(4'd7, 32'h2, 3'd0);
    send(4'd15, 32'h3, 3'd0);
    @(negedge clk);
    chk("illegal_no_valid", req_valid, 0);
    chk("illegal_dropped3", dropped_cnt, 3);
    chk("illegal_no_events", obs_q.size(), 0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(5, 15);
      if (r == 8 || r == 9) r = 7;
      in_n = r[3:0]; in_addr = $urandom;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("dropped_saturates", dropped_cnt, (illegal > 255) ? 255 : illegal);
    chk("dropped_is_255", dropped_cnt, 255);
    @(posedge clk); #1;

    // Print strobe width, then reset in the middle of a clear and of a stall.
    do_reset(0);
    send(4'd9, 32'h0, 3'd0);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (print_pulse) cnt++;
    end
    chk("print_pulse_cycles", cnt, 1);
    @(posedge clk); #1;
    ack_delay = 1000;
    send(4'd8, 32'h0, 3'd0);
    send(4'd2, 32'h1234_5678, 3'd3);
    cnt = 0;
    while (!flush_req && cnt < 50) begin @(posedge clk); #1; cnt++; end
    chk("flush_seen", flush_req, 1);
    do_reset(1);
    repeat (3) begin
      @(negedge clk);
      chk("no_flush_after_reset", {flush_req, req_valid}, 2'b00);
    end
    @(posedge clk); #1;
    ack_delay = 3;
    send(4'd3, 32'h5555_0000, 3'd4);
    @(negedge clk);
    chk("stalled_valid", req_valid, 1);
    do_reset(0);
    @(negedge clk);
    chk("stall_abandoned", {req_valid, req_tag, req_set, req_offset}, 0);
    @(posedge clk); #1;

    // Random traffic against the event-order model.
    do_reset(0);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 2) != 0);
        r = $urandom_range(0, 15);
        if (r < 10) in_n = 4'($urandom_range(0, 4));
        else if (r < 12) in_n = 4'd8;
        else if (r == 12) in_n = 4'd9;
        else in_n = 4'($urandom_range(10, 15));
        in_addr = $urandom;
        in_pid = 3'($urandom_range(0, 7));
      end
      req_ready = ($urandom_range(0, 3) != 0);
      ack_delay = $urandom_range(1, 4);
    end
    in_valid = 1'b0; req_ready = 1'b1; ack_delay = 2;
    cnt = 0;
    while (!(pushed == popped && flush_len == 0 && !print_pulse && !flush_req) && cnt < 300) begin
      @(posedge clk); #1;
      cnt++;
    end
    chk("drain_timeout", cnt < 300, 1);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    compare_queues("rand");
    cnt = 0;
    foreach (exp_q[i]) if (exp_q[i].kind == 2'd0) cnt++;
    chk("rand_issued_cnt", issued_cnt, cnt % (1 << CNT_W));
    chk("rand_dropped_cnt", dropped_cnt, (illegal > 255) ? 255 : illegal);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
